uproc_core: RTL and testbench
=============================

Name: uproc_core

Overview:
Parametrised successor of the 8-bit accumulator microprocessor. It is a single self-contained accumulator core: a fetch/execute state machine, a register file, an ALU, a carry flag and an accumulator. Instruction fetch uses a handshaked memory interface of variable latency. Adds conditional/unconditional jumps, an immediate load, a handshaked output port and a halt state. Sits at the top of the processor hierarchy; program memory lives outside the block.

Parameters:
DATA_W, 8, accumulator/register/ALU width (>=2)
NREGS, 16, register file depth (power of 2, >=2); REG_AW = clog2(NREGS)
PC_W, 5, program counter width; program space 2^PC_W words
OPND_W, 5, operand field width, >= max(REG_AW, PC_W); INSTR_W = 4 + OPND_W

Ports:
clk  in  1  clock, all state on rising edge
nReset  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; high only in FETCH
imem_addr  out  PC_W  fetch address, equals PC
imem_valid  in  1  instruction valid; sampled only while imem_req=1
imem_data  in  INSTR_W  instruction: [INSTR_W-1:OPND_W] opcode, [OPND_W-1:0] operand
out_valid  out  1  output word valid
out_data  out  DATA_W  output word, stable while out_valid=1
out_ready  in  1  consumer accepts on out_valid & out_ready
halted  out  1  core is in HALT
acc  out  DATA_W  accumulator, for debug

Behaviour:
- Reset (async, nReset=0): PC=0, A=0, CY=0, all registers 0, IR=0, state FETCH, out_valid=0, out_data=0, halted=0.
- States: FETCH, EXEC, OUT_WAIT, HALT.
- FETCH: imem_req=1, imem_addr=PC. When imem_valid=1, latch imem_data into IR and go to EXEC. Otherwise hold; wait is unbounded.
- EXEC: takes one cycle. R = reg[operand[REG_AW-1:0]]; upper operand bits are ignored. PC advances as PC+1 mod 2^PC_W unless the instruction jumps. Next state is FETCH unless noted.
- Opcodes:
  - 0 NOP.
  - 1 LDR: A<=R.
  - 2 STR: reg<=A.
  - 3 ADD: {CY,A}<=A+R.
  - 4 ADC: {CY,A}<=A+R+CY.
  - 5 SUB: A<=A-R, CY<=1 iff A<R (borrow).
  - 6 AND, 7 OR, 8 XOR: A<=A op R, CY unchanged.
  - 9 CLC: CY<=0.
  - A LDI: A<=operand, zero-extended or truncated to DATA_W.
  - B JMP: PC<=operand[PC_W-1:0].
  - C JC: jump if CY=1.
  - D JZ: jump if A==0, using the pre-execute A.
  - E OUT: out_data<=A, out_valid<=1, PC<=PC+1, go to OUT_WAIT.
  - F HLT: PC unchanged, go to HALT.
- OUT_WAIT: out_valid=1. On out_ready=1, out_valid<=0 and go to FETCH. out_ready while out_valid=0 is ignored.
- HALT: halted=1, imem_req=0. Only reset leaves this state.
- Throughput: with imem_valid high in the request cycle, one instruction takes 2 cycles; OUT takes at least 3.
- PC wraps from 2^PC_W-1 to 0 with no flag. JMP to the current PC forms a legal infinite loop.
- Register writes and A/CY updates all occur at the EXEC clock edge. No bypass is needed because each instruction completes before the next fetch.
- Reset mid-fetch or mid-OUT_WAIT: immediate return to reset values. A pending output word is dropped.

Optional Feature:
UPROC_PERF_EN:
- Defined: adds output port retired (32 bits). It resets to 0 and increments by 1 at every EXEC cycle, HLT included, wrapping at 2^32.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package uproc_pkg: opcode enum (4-bit, values above), state enum, alu_op enum, a helper function for the operand register index.
- Natural sub-module uproc_alu: combinational, inputs alu_op, A, R, CY; outputs result and carry-out. Parametrised by DATA_W. The core instantiates it once.

Test Plan:
- Reset then program LDI 5; STR r3; LDI 7; ADD r3; OUT; HLT with zero-wait memory -> out_data=12 with out_valid=1; halted=1 after 13 cycles; imem_req=0 thereafter.
- DATA_W=8: LDI 200 (OPND_W=8 build); STR r1; ADD r1 -> A=144, CY=1. Then ADC r0 (r0=0) -> A=145, CY=0.
- SUB borrow: A=3, r2=5, SUB r2 -> A=254, CY=1. JC 9 -> next imem_addr=9. CLC; JC 0 -> falls through to PC+1.
- Fetch stalls: imem_valid withheld 4 cycles on each fetch -> imem_addr held at PC and imem_req held high. Architectural result matches the zero-wait run.
- Output backpressure: out_ready low 6 cycles after OUT -> out_valid and out_data stable and no further imem_req. out_ready pulse -> out_valid drops next cycle and fetch resumes at PC+1.
- Wrap/reset: PC=31 executing NOP (PC_W=5) -> next imem_addr=0. Assert nReset in OUT_WAIT -> out_valid=0, PC=0, A=0 immediately. With UPROC_PERF_EN, retired=0.

Source files
------------

// File: rtl/uproc_pkg.sv
// rtl/uproc_pkg.sv - shared opcode, state and ALU encodings for the accumulator core
package uproc_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDR = 4'h1,
    OP_STR = 4'h2,
    OP_ADD = 4'h3,
    OP_ADC = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_CLC = 4'h9,
    OP_LDI = 4'hA,
    OP_JMP = 4'hB,
    OP_JC  = 4'hC,
    OP_JZ  = 4'hD,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_OUT_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_ADC  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_XOR  = 3'd6
  } alu_op_e;

  // Register index is the low reg_aw bits of the operand; upper bits are don't-care.
  function automatic int unsigned reg_index(input int unsigned operand, input int unsigned reg_aw);
    return operand & ((32'd1 << reg_aw) - 32'd1);
  endfunction

endpackage

// File: rtl/uproc_alu.sv
// rtl/uproc_alu.sv - combinational ALU; carry_out is the carry or borrow for arithmetic ops, cy_in otherwise
module uproc_alu
  import uproc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] r,
  input  logic              cy_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum       = '0;
    result    = a;
    carry_out = cy_in;
    case (alu_op)
      ALU_PASS: result = r;
      ALU_ADD: begin
        sum       = {1'b0, a} + {1'b0, r};
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      ALU_ADC: begin
        sum       = {1'b0, a} + {1'b0, r} + {{DATA_W{1'b0}}, cy_in};
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      ALU_SUB: begin
        // The extra top bit goes high exactly when a < r, which is the borrow.
        sum       = {1'b0, a} - {1'b0, r};
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      ALU_AND: result = a & r;
      ALU_OR:  result = a | r;
      ALU_XOR: result = a ^ r;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/uproc_core.sv
// rtl/uproc_core.sv - accumulator core: handshaked fetch, execute, output port, halt
// Optional UPROC_PERF_EN adds the 32-bit retired-instruction counter port.
module uproc_core
  import uproc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 16,
  parameter  int PC_W    = 5,
  parameter  int OPND_W  = 5,
  localparam int REG_AW  = $clog2(NREGS),
  localparam int INSTR_W = 4 + OPND_W
) (
  input  logic               clk,
  input  logic               nReset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               halted,
  output logic [DATA_W-1:0]  acc
`ifdef UPROC_PERF_EN
  ,
  output logic [31:0]        retired
`endif
);

  localparam logic [1:0] S_FETCH    = ST_FETCH;
  localparam logic [1:0] S_EXEC     = ST_EXEC;
  localparam logic [1:0] S_OUT_WAIT = ST_OUT_WAIT;
  localparam logic [1:0] S_HALT     = ST_HALT;

  logic [1:0]         state;
  logic [PC_W-1:0]    pc;
  logic [DATA_W-1:0]  a;
  logic               cy;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NREGS];

  opcode_e            opcode;
  logic [OPND_W-1:0]  operand;
  logic [REG_AW-1:0]  r_idx;
  logic [DATA_W-1:0]  rval;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    jmp_tgt;
  alu_op_e            alu_op;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_cy;

  assign opcode  = opcode_e'(ir[INSTR_W-1:OPND_W]);
  assign operand = ir[OPND_W-1:0];
  assign r_idx   = REG_AW'(reg_index(32'(operand), REG_AW));
  assign rval    = regs[r_idx];
  assign pc_inc  = pc + PC_W'(1);
  assign jmp_tgt = operand[PC_W-1:0];

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign acc       = a;

  always_comb begin
    alu_op = ALU_PASS;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_ADC:  alu_op = ALU_ADC;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      default: alu_op = ALU_PASS;
    endcase
  end

  uproc_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op    (alu_op),
    .a         (a),
    .r         (rval),
    .cy_in     (cy),
    .result    (alu_res),
    .carry_out (alu_cy)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_FETCH;
      pc        <= '0;
      a         <= '0;
      cy        <= 1'b0;
      ir        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc_inc;
          case (opcode)
            OP_LDR, OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              a  <= alu_res;
              cy <= alu_cy;
            end
            OP_STR: regs[r_idx] <= a;
            OP_CLC: cy <= 1'b0;
            OP_LDI: a <= DATA_W'(operand);
            OP_JMP: pc <= jmp_tgt;
            OP_JC:  if (cy) pc <= jmp_tgt;
            // Tests the accumulator as it stood before this instruction.
            OP_JZ:  if (a == '0) pc <= jmp_tgt;
            OP_OUT: begin
              out_data  <= a;
              out_valid <= 1'b1;
              state     <= S_OUT_WAIT;
            end
            OP_HLT: begin
              pc    <= pc;
              state <= S_HALT;
            end
            default: ;
          endcase
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UPROC_PERF_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) retired <= '0;
    else if (state == S_EXEC) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_uproc_core.sv
// tb/tb_uproc_core.sv - directed and random-program checks of uproc_core against an ISA-level model
`timescale 1ns/1ps
module tb_uproc_core;

    localparam int DW = 8;
    localparam int PW = 5;
    localparam int OW = 8;
    localparam int IW = 4 + OW;

    logic          clk = 1'b0;
    logic          nReset;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_valid;
    logic [IW-1:0] imem_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          halted;
    logic [DW-1:0] acc;
`ifdef UPROC_PERF_EN
    logic [31:0]   retired;
`endif

    uproc_core #(.DATA_W(DW), .NREGS(16), .PC_W(PW), .OPND_W(OW)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .halted     (halted),
        .acc        (acc)
`ifdef UPROC_PERF_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [IW-1:0] prog [32];
    logic [7:0]    outs [$];
    int            exp_outs [$];
    int            stall_len  = 0;
    int            stall_cnt  = 0;
    int            ready_mode = 0;
    logic [PW-1:0] stall_addr = '0;

    task automatic fail(input string tag, input longint obs, input longint exp);
        n_err++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [IW-1:0] ins(input int op, input int opd);
        logic [3:0] o;
        logic [7:0] d;
        o = 4'(op);
        d = 8'(opd);
        return {o, d};
    endfunction

    task automatic fill_hlt();
        for (int i = 0; i < 32; i++) prog[i] = ins(15, 0);
    endtask

    task automatic do_reset();
        nReset     = 1'b0;
        imem_valid = 1'b0;
        imem_data  = '0;
        out_ready  = 1'b0;
        stall_cnt  = 0;
        outs.delete();
        repeat (2) @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic step();
        if (stall_cnt > 0) begin
            n_cmp++; if (imem_req !== 1'b1) fail("stall_req", imem_req, 1);
            n_cmp++; if (imem_addr !== stall_addr) fail("stall_addr", imem_addr, stall_addr);
        end
        if (imem_req) begin
            if (stall_cnt == 0) stall_addr = imem_addr;
            if (stall_cnt < stall_len) begin
                imem_valid = 1'b0;
                imem_data  = IW'($urandom);
                stall_cnt++;
            end else begin
                imem_valid = 1'b1;
                imem_data  = prog[imem_addr];
                stall_cnt  = 0;
            end
        end else begin
            imem_valid = 1'b0;
            imem_data  = IW'($urandom);
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        if (out_valid && out_ready) outs.push_back(out_data);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_halt(input int budget);
        int c;
        c = 0;
        while (!halted && c < budget) begin
            step();
            c++;
        end
        n_cmp++; if (halted !== 1'b1) fail("halt_within_budget", halted, 1);
    endtask

    task automatic model_run(output int m_a, output int m_pc, output int m_exec);
        int a, cy, pc, npc, op, opd, r, s, ri;
        int regs [16];
        a = 0; cy = 0; pc = 0; m_exec = 0;
        for (int i = 0; i < 16; i++) regs[i] = 0;
        exp_outs.delete();
        while (m_exec < 1000) begin
            op  = int'(prog[pc][11:8]);
            opd = int'(prog[pc][7:0]);
            ri  = opd % 16;
            r   = regs[ri];
            npc = (pc + 1) % 32;
            m_exec++;
            if (op == 15) break;
            case (op)
                1:  a = r;
                2:  regs[ri] = a;
                3:  begin s = a + r;      cy = (s > 255) ? 1 : 0; a = s % 256; end
                4:  begin s = a + r + cy; cy = (s > 255) ? 1 : 0; a = s % 256; end
                5:  begin cy = (a < r) ? 1 : 0; a = (a - r + 256) % 256; end
                6:  a = a & r;
                7:  a = a | r;
                8:  a = a ^ r;
                9:  cy = 0;
                10: a = opd % 256;
                11: npc = opd % 32;
                12: if (cy == 1) npc = opd % 32;
                13: if (a == 0) npc = opd % 32;
                14: exp_outs.push_back(a);
                default: ;
            endcase
            pc = npc;
        end
        m_a  = a;
        m_pc = pc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_a, m_pc, m_exec, op, tgt;

        nReset = 1'b0; imem_valid = 1'b0; imem_data = '0; out_ready = 1'b0;
        #13;
        n_cmp++; if (out_valid !== 1'b0) fail("rst_out_valid", out_valid, 0);
        n_cmp++; if (out_data !== 8'd0) fail("rst_out_data", out_data, 0);
        n_cmp++; if (halted !== 1'b0) fail("rst_halted", halted, 0);
        n_cmp++; if (acc !== 8'd0) fail("rst_acc", acc, 0);
        n_cmp++; if (imem_addr !== 5'd0) fail("rst_addr", imem_addr, 0);
        n_cmp++; if (imem_req !== 1'b1) fail("rst_req", imem_req, 1);
`ifdef UPROC_PERF_EN
        n_cmp++; if (retired !== 32'd0) fail("rst_retired", retired, 0);
`endif

        fill_hlt();
        prog[0] = ins(10, 5); prog[1] = ins(2, 3); prog[2] = ins(10, 7);
        prog[3] = ins(3, 3);  prog[4] = ins(14, 0); prog[5] = ins(15, 0);
        stall_len = 0; ready_mode = 0;
        do_reset();
        steps(12);
        n_cmp++; if (halted !== 1'b0) fail("p1_not_halted_at_12", halted, 0);
        step();
        n_cmp++; if (halted !== 1'b1) fail("p1_halted_at_13", halted, 1);
        n_cmp++; if (outs.size() != 1) fail("p1_out_count", outs.size(), 1);
        if (outs.size() > 0) begin
            n_cmp++; if (outs[0] !== 8'd12) fail("p1_out_data", outs[0], 12);
        end
        steps(3);
        n_cmp++; if (imem_req !== 1'b0) fail("p1_req_after_halt", imem_req, 0);
        n_cmp++; if (imem_addr !== 5'd5) fail("p1_pc_at_hlt", imem_addr, 5);
`ifdef UPROC_PERF_EN
        n_cmp++; if (retired !== 32'd6) fail("p1_retired", retired, 6);
`endif

        stall_len = 4;
        do_reset();
        run_halt(200);
        n_cmp++; if (outs.size() != 1) fail("stall_out_count", outs.size(), 1);
        if (outs.size() > 0) begin
            n_cmp++; if (outs[0] !== 8'd12) fail("stall_out_data", outs[0], 12);
        end
        n_cmp++; if (acc !== 8'd12) fail("stall_acc", acc, 12);
        stall_len = 0;

        fill_hlt();
        prog[0] = ins(10, 200); prog[1] = ins(2, 8'hF1); prog[2] = ins(3, 8'h71);
        prog[3] = ins(12, 6);   prog[6] = ins(4, 8'h30); prog[7] = ins(12, 20);
        prog[8] = ins(13, 20);  prog[9] = ins(10, 0);    prog[10] = ins(13, 13);
        do_reset();
        steps(6);
        n_cmp++; if (acc !== 8'd144) fail("add_acc_144", acc, 144);
        steps(2);
        n_cmp++; if (imem_addr !== 5'd6) fail("jc_taken_addr", imem_addr, 6);
        steps(2);
        n_cmp++; if (acc !== 8'd145) fail("adc_acc_145", acc, 145);
        steps(2);
        n_cmp++; if (imem_addr !== 5'd8) fail("jc_not_taken_addr", imem_addr, 8);
        steps(2);
        n_cmp++; if (imem_addr !== 5'd9) fail("jz_not_taken_addr", imem_addr, 9);
        run_halt(100);
        n_cmp++; if (imem_addr !== 5'd13) fail("jz_taken_final_pc", imem_addr, 13);
        n_cmp++; if (acc !== 8'd0) fail("jz_final_acc", acc, 0);

        fill_hlt();
        prog[0] = ins(10, 5); prog[1] = ins(2, 2);  prog[2] = ins(10, 3);
        prog[3] = ins(5, 8'h32); prog[4] = ins(12, 9);
        prog[9] = ins(9, 0);  prog[10] = ins(12, 0);
        do_reset();
        steps(8);
        n_cmp++; if (acc !== 8'd254) fail("sub_acc_254", acc, 254);
        steps(2);
        n_cmp++; if (imem_addr !== 5'd9) fail("sub_jc_addr", imem_addr, 9);
        steps(4);
        n_cmp++; if (imem_addr !== 5'd11) fail("clc_jc_fallthrough", imem_addr, 11);
        run_halt(100);
        n_cmp++; if (imem_addr !== 5'd11) fail("sub_final_pc", imem_addr, 11);

        fill_hlt();
        prog[0] = ins(10, 8'h5A); prog[1] = ins(14, 0); prog[2] = ins(10, 1); prog[3] = ins(14, 0);
        ready_mode = 2;
        do_reset();
        steps(4);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (out_valid !== 1'b1) fail("bp_valid_held", out_valid, 1);
            n_cmp++; if (out_data !== 8'h5A) fail("bp_data_held", out_data, 8'h5A);
            n_cmp++; if (imem_req !== 1'b0) fail("bp_no_fetch", imem_req, 0);
            step();
        end
        ready_mode = 0;
        step();
        n_cmp++; if (out_valid !== 1'b0) fail("bp_valid_drop", out_valid, 0);
        n_cmp++; if (imem_req !== 1'b1) fail("bp_fetch_resume", imem_req, 1);
        n_cmp++; if (imem_addr !== 5'd2) fail("bp_resume_addr", imem_addr, 2);
        run_halt(100);
        n_cmp++; if (outs.size() != 2) fail("bp_out_count", outs.size(), 2);
        if (outs.size() > 1) begin
            n_cmp++; if (outs[1] !== 8'd1) fail("bp_second_word", outs[1], 1);
        end

        fill_hlt();
        prog[0] = ins(11, 8'hFF); prog[31] = ins(0, 0);
        do_reset();
        steps(2);
        n_cmp++; if (imem_addr !== 5'd31) fail("wrap_at_31", imem_addr, 31);
        steps(2);
        n_cmp++; if (imem_addr !== 5'd0) fail("wrap_to_0", imem_addr, 0);

        fill_hlt();
        prog[0] = ins(10, 9); prog[1] = ins(14, 0);
        ready_mode = 2;
        do_reset();
        steps(4);
        n_cmp++; if (out_valid !== 1'b1) fail("ow_pending", out_valid, 1);
        nReset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) fail("ow_rst_valid", out_valid, 0);
        n_cmp++; if (imem_addr !== 5'd0) fail("ow_rst_addr", imem_addr, 0);
        n_cmp++; if (acc !== 8'd0) fail("ow_rst_acc", acc, 0);
        n_cmp++; if (halted !== 1'b0) fail("ow_rst_halted", halted, 0);
`ifdef UPROC_PERF_EN
        n_cmp++; if (retired !== 32'd0) fail("ow_rst_retired", retired, 0);
`endif

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 31; i++) begin
                op = int'($urandom_range(0, 15));
                if (op >= 11 && op <= 13) begin
                    tgt = int'($urandom_range(i + 1, 31));
                    prog[i] = ins(op, (int'($urandom_range(0, 7)) << 5) | tgt);
                end else begin
                    prog[i] = ins(op, int'($urandom_range(0, 255)));
                end
            end
            prog[31] = ins(15, 0);
            model_run(m_a, m_pc, m_exec);
            stall_len  = int'($urandom_range(0, 3));
            ready_mode = 1;
            do_reset();
            run_halt(3000);
            n_cmp++; if (outs.size() != exp_outs.size()) fail("rnd_out_count", outs.size(), exp_outs.size());
            for (int i = 0; i < outs.size() && i < exp_outs.size(); i++) begin
                n_cmp++; if (outs[i] !== 8'(exp_outs[i])) fail("rnd_out_word", outs[i], exp_outs[i]);
            end
            n_cmp++; if (acc !== 8'(m_a)) fail("rnd_acc", acc, m_a);
            n_cmp++; if (imem_addr !== 5'(m_pc)) fail("rnd_pc", imem_addr, m_pc);
            n_cmp++; if (imem_req !== 1'b0) fail("rnd_req_low", imem_req, 0);
`ifdef UPROC_PERF_EN
            n_cmp++; if (retired !== 32'(m_exec)) fail("rnd_retired", retired, m_exec);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
